instr_fetch_unit: RTL
=====================

// Module: instr_fetch_unit
// PURPOSE
//  Reader side of the Instruction_Ram port. Owns the program counter and drives `address`.
//  Absorbs the RAM's one-cycle registered read latency and latches the 16-bit word into an IR.
//  Splits the word into opcode[15:10] and operand[9:0].
//  Hands the decoded instruction to the control unit with a valid/ready handshake and applies
//  branch redirects (JUMPZ/JUMPNZ). Stops on the program terminator NOP.
// PARAMETERS
//  ADDR_W      9    width of the instruction address / PC
//  INSTR_W     16   instruction word width
//  OPC_W       6    opcode field width (instr[15:10])
//  INST_DEPTH  201  number of valid RAM words; PC/target >= INST_DEPTH is a fault
//  HALT_OP     46   opcode that ends fetching (NOP)
// PORTS
//  clk            in   1        rising-edge clock shared with Instruction_Ram
//  rst            in   1        asynchronous, active-high reset
//  fetch_en       in   1        start/continue fetching; low stalls in ISSUE/IDLE
//  address        out  ADDR_W   to Instruction_Ram.address; equals pc_q
//  instr_in       in   INSTR_W  from Instruction_Ram.instr_out (valid 1 clk after address)
//  ir_valid       out  1        opcode/operand/ir_pc hold a fetched instruction
//  ir_ready       in   1        control unit consumes the instruction this cycle
//  opcode         out  OPC_W    IR[15:10]
//  operand        out  10       IR[9:0] (immediate or jump address)
//  ir_pc          out  ADDR_W   address the current IR was fetched from
//  branch_taken   in   1        sampled only with ir_valid&ir_ready; redirect PC
//  branch_target  in   ADDR_W   new PC when branch_taken
//  halted         out  1        HALT_OP fetched, sticky until rst
//  fault          out  1        out-of-range PC or target, sticky until rst
// BEHAVIOUR
//  Reset (async, any state): state=IDLE, pc_q=0, IR=0, ir_pc=0.
//   address=0, ir_valid=0, halted=0, fault=0.
//  FSM states: IDLE, ISSUE, WAIT, HOLD, HALT.
//   IDLE : fetch_en=1 -> ISSUE.
//   ISSUE: address=pc_q is presented; RAM captures it at this edge. fetch_en=1 -> WAIT,
//          else stay in ISSUE.
//   WAIT : instr_in is valid; latch IR<=instr_in and ir_pc<=pc_q.
//          Next state is HALT if instr_in[15:10]==HALT_OP, else HOLD.
//   HOLD : ir_valid=1. IR is stable until the handshake, whatever fetch_en does.
//          On ir_valid&ir_ready:
//            branch_taken=1 -> pc_q<=branch_target; target>=INST_DEPTH -> fault=1, HALT.
//            otherwise      -> pc_q<=pc_q+1; result >= INST_DEPTH -> fault=1, HALT.
//          Then -> ISSUE.
//   HALT : ir_valid=1 with IR = terminator (or the instruction being consumed at the fault).
//          halted=1 only for the terminator case. Ignores fetch_en, ir_ready and branch inputs.
//          Only rst leaves HALT.
//  Latency: pc_q update -> IR valid is 2 clocks (ISSUE, WAIT).
//   Best-case throughput is 1 instruction per 3 clocks with ir_ready held high.
//  ir_ready while ir_valid=0 is ignored. branch_* is ignored outside the handshake cycle.
//  PC arithmetic is ADDR_W unsigned; the +1 never wraps silently (fault instead).
//  The operand is passed through unmodified. No sign extension; the consumer decides.
//  rst mid-WAIT: the in-flight RAM word is discarded and the next fetch restarts at 0.
// STRUCTURE
//  Shared package conv_isa_pkg holds:
//   - opcode localparams (FETCH=0, CLAC=2, ..., JUMPNZ=47, JUMPZ=52, DECAC=59, NOP=46)
//   - OPC_W, OPERAND_W=10, ADDR_W, INSTR_W
//   - the FSM state encoding.
//  Single flat module; no sub-module is warranted.
//  The address mux and field split are a few assigns.
// TESTING (bench pairs the DUT with Instruction_Ram)
//  1. rst=1 then release, fetch_en=1, ir_ready=1.
//     -> address 0,1,2,...; opcodes 0,2,3,4,6 in order; ir_valid every 3rd clk.
//  2. ir_ready=0 for 10 clks during HOLD at pc=5.
//     -> opcode=2 (CLAC) and ir_pc=5 stay stable; pc stays 5; resumes at 6 when ready=1.
//  3. Handshake at ir_pc=184 with branch_taken=1, target=63.
//     -> next address=63, next opcode=24 (MVACCV), ir_pc=63.
//  4. Run to pc=185 with no branch.
//     -> opcode=46 latched, halted=1, ir_valid=1; address holds 185 for 50 clks under any inputs.
//  5. branch_taken=1, target=300.
//     -> fault=1, HALT, no fetch from 300. Pulse rst -> fault=0, address=0.
//  6. Assert rst in WAIT of pc=10.
//     -> ir_valid=0 immediately, no IR update. After release, first IR is from address 0.

Source files
------------

// File: rtl/conv_isa_pkg.sv
// Shared ISA definitions for the conv processor: field widths, opcode
// values and the fetch-unit state encoding.
package conv_isa_pkg;

  // Instruction word layout: opcode in the top bits, operand below it
  localparam int unsigned ADDR_W     = 9;
  localparam int unsigned INSTR_W    = 16;
  localparam int unsigned OPC_W      = 6;
  localparam int unsigned OPERAND_W  = INSTR_W - OPC_W;
  localparam int unsigned INST_DEPTH = 201;

  // Opcodes referenced by the fetch path and its test programs
  localparam logic [OPC_W-1:0] OPC_FETCH  = 6'd0;
  localparam logic [OPC_W-1:0] OPC_CLAC   = 6'd2;
  localparam logic [OPC_W-1:0] OPC_MVACCV = 6'd24;
  localparam logic [OPC_W-1:0] OPC_NOP    = 6'd46;
  localparam logic [OPC_W-1:0] OPC_JUMPNZ = 6'd47;
  localparam logic [OPC_W-1:0] OPC_JUMPZ  = 6'd52;
  localparam logic [OPC_W-1:0] OPC_DECAC  = 6'd59;

  // Fetch FSM: IDLE -> ISSUE (address out) -> WAIT (RAM data back)
  // -> HOLD (IR offered) -> ISSUE ..., with HALT as the absorbing state.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_WAIT  = 3'd2,
    ST_HOLD  = 3'd3,
    ST_HALT  = 3'd4
  } fetch_state_e;

endpackage : conv_isa_pkg

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns the PC, drives the instruction RAM address,
// absorbs the RAM's one-cycle read latency into an IR and offers the decoded
// instruction to the control unit over a valid/ready handshake. Branch
// redirects are taken at the handshake; the NOP terminator or an
// out-of-range PC/target parks the unit in HALT until reset.
module instr_fetch_unit #(
  parameter int unsigned ADDR_W     = conv_isa_pkg::ADDR_W,
  parameter int unsigned INSTR_W    = conv_isa_pkg::INSTR_W,
  parameter int unsigned OPC_W      = conv_isa_pkg::OPC_W,
  parameter int unsigned INST_DEPTH = conv_isa_pkg::INST_DEPTH,
  parameter int unsigned HALT_OP    = 46
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       fetch_en,
  output logic [ADDR_W-1:0]          address,
  input  logic [INSTR_W-1:0]         instr_in,
  output logic                       ir_valid,
  input  logic                       ir_ready,
  output logic [OPC_W-1:0]           opcode,
  output logic [INSTR_W-OPC_W-1:0]   operand,
  output logic [ADDR_W-1:0]          ir_pc,
  input  logic                       branch_taken,
  input  logic [ADDR_W-1:0]          branch_target,
  output logic                       halted,
  output logic                       fault
);

  import conv_isa_pkg::*;

  // One extra bit so the PC increment can never wrap before the range check
  localparam logic [ADDR_W:0]    DEPTH_X  = INST_DEPTH[ADDR_W:0];
  localparam logic [OPC_W-1:0]   HALT_OPC = HALT_OP[OPC_W-1:0];

  fetch_state_e         state_q, state_d;
  logic [ADDR_W-1:0]    pc_q, pc_d;
  logic [INSTR_W-1:0]   ir_q, ir_d;
  logic [ADDR_W-1:0]    ir_pc_q, ir_pc_d;
  logic                 halted_q, halted_d;
  logic                 fault_q, fault_d;

  logic [ADDR_W:0]      pc_inc;
  logic [ADDR_W:0]      pc_next;
  logic                 handshake;

  // True when an extended address lies inside the populated RAM
  function automatic logic addr_in_range(input logic [ADDR_W:0] a);
    return a < DEPTH_X;
  endfunction

  assign pc_inc    = {1'b0, pc_q} + {{ADDR_W{1'b0}}, 1'b1};
  assign pc_next   = branch_taken ? {1'b0, branch_target} : pc_inc;
  assign handshake = (state_q == ST_HOLD) && ir_ready;

  assign address   = pc_q;
  assign ir_valid  = (state_q == ST_HOLD) || (state_q == ST_HALT);
  assign opcode    = ir_q[INSTR_W-1:INSTR_W-OPC_W];
  assign operand   = ir_q[INSTR_W-OPC_W-1:0];
  assign ir_pc     = ir_pc_q;
  assign halted    = halted_q;
  assign fault     = fault_q;

  // State and datapath registers; reset discards any in-flight RAM word
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      pc_q     <= '0;
      ir_q     <= '0;
      ir_pc_q  <= '0;
      halted_q <= 1'b0;
      fault_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      ir_q     <= ir_d;
      ir_pc_q  <= ir_pc_d;
      halted_q <= halted_d;
      fault_q  <= fault_d;
    end
  end

  // Next-state logic: sequencing, IR capture, PC advance/redirect, halt/fault
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    ir_d     = ir_q;
    ir_pc_d  = ir_pc_q;
    halted_d = halted_q;
    fault_d  = fault_q;

    unique case (state_q)
      ST_IDLE: begin
        if (fetch_en) state_d = ST_ISSUE;
      end

      // The RAM samples address at the edge that leaves this state
      ST_ISSUE: begin
        if (fetch_en) state_d = ST_WAIT;
      end

      // RAM data for pc_q is on instr_in now
      ST_WAIT: begin
        ir_d    = instr_in;
        ir_pc_d = pc_q;
        if (instr_in[INSTR_W-1:INSTR_W-OPC_W] == HALT_OPC) begin
          halted_d = 1'b1;
          state_d  = ST_HALT;
        end else begin
          state_d  = ST_HOLD;
        end
      end

      // IR is frozen until consumed; a bad next PC faults without being
      // loaded, so the RAM never sees an out-of-range address
      ST_HOLD: begin
        if (handshake) begin
          if (addr_in_range(pc_next)) begin
            pc_d    = pc_next[ADDR_W-1:0];
            state_d = ST_ISSUE;
          end else begin
            fault_d = 1'b1;
            state_d = ST_HALT;
          end
        end
      end

      // Absorbing: only rst leaves
      ST_HALT: begin
        state_d = ST_HALT;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

endmodule : instr_fetch_unit
